// File: rtl/tx_arbiter_pkg.sv
// Shared types and widths for the transmit arbiter and the per-stock systems.
package tx_arbiter_pkg;

  localparam int PRICE_W = 32;
  localparam int VOL_W   = 32;
  localparam int ADDR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  // One order as presented by a trading system.
  typedef struct packed {
    logic               side;
    logic [PRICE_W-1:0] price;
    logic [VOL_W-1:0]   vol;
  } order_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Order request bus from the systems plus the UART transmit handshake.
interface tx_arbiter_if
  import tx_arbiter_pkg::*;
#(
  parameter int N_SYS = 4
);

  logic [N_SYS-1:0]         ord_req;
  logic [N_SYS-1:0]         ord_side;
  logic [PRICE_W*N_SYS-1:0] ord_price;
  logic [VOL_W*N_SYS-1:0]   ord_vol;
  logic [N_SYS-1:0]         ord_ack;

  logic [ADDR_W-1:0]        tx_addr;
  logic                     tx_side;
  logic [PRICE_W-1:0]       tx_price;
  logic [VOL_W-1:0]         tx_vol;
  logic                     tx_dv;
  logic                     tx_done;

  // Arbiter side.
  modport master (
    input  ord_req, ord_side, ord_price, ord_vol, tx_done,
    output ord_ack, tx_addr, tx_side, tx_price, tx_vol, tx_dv
  );

  // Systems and UART side.
  modport slave (
    output ord_req, ord_side, ord_price, ord_vol, tx_done,
    input  ord_ack, tx_addr, tx_side, tx_price, tx_vol, tx_dv
  );

endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module tx_arbiter_rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int N_SYS = 4,
  localparam int IDX_W = idx_width(N_SYS)
) (
  input  logic [N_SYS-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // Walk offsets from farthest to nearest so the nearest set bit is the last one written.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N_SYS - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % N_SYS]) begin
        winner = IDX_W'((int'(rr_ptr) + i) % N_SYS);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Shares the single UART transmit path between the trading systems.
//
// state | meaning
// IDLE  | waiting for any request; grants the round-robin winner
// SEND  | tx_dv high for this one cycle, fields valid
// WAIT  | waiting for tx_done, aborts after TIMEOUT_CYCLES
// GAP   | GAP_CYCLES guard cycles, requests ignored
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int N_SYS          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset,
  tx_arbiter_if.master bus,
  output logic         busy,
  output logic         err_timeout,
  output logic [31:0]  tx_count
);

  localparam int IDX_W  = idx_width(N_SYS);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [N_SYS-1:0]   ack_q, ack_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  order_t             order_q, order_d;
  logic               dv_q, dv_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [31:0]        count_q, count_d;

  logic [IDX_W-1:0]   winner;
  logic               win_valid;

  tx_arbiter_rr_pick #(
    .N_SYS (N_SYS)
  ) u_pick (
    .req    (bus.ord_req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .valid  (win_valid)
  );

  // Next-state and registered-output computation; everything not assigned holds or pulses low.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ack_d      = '0;
    addr_d     = addr_q;
    order_d    = order_q;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    count_d    = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d       = ST_SEND;
          ack_d         = N_SYS'(1) << winner;
          addr_d        = ADDR_W'(winner);
          order_d.side  = bus.ord_side[winner];
          order_d.price = bus.ord_price[int'(winner) * PRICE_W +: PRICE_W];
          order_d.vol   = bus.ord_vol[int'(winner) * VOL_W +: VOL_W];
          rr_ptr_d      = (winner == IDX_W'(N_SYS - 1)) ? '0 : winner + IDX_W'(1);
          dv_d          = 1'b1;
        end
      end
      ST_SEND: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        // A completion on the last allowed cycle still counts as a send.
        if (bus.tx_done) begin
          count_d   = count_q + 32'd1;
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d     = 1'b1;
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any send in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      ack_q      <= '0;
      addr_q     <= '0;
      order_q    <= '0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_q      <= ack_d;
      addr_q     <= addr_d;
      order_q    <= order_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign bus.ord_ack  = ack_q;
  assign bus.tx_addr  = addr_q;
  assign bus.tx_side  = order_q.side;
  assign bus.tx_price = order_q.price;
  assign bus.tx_vol   = order_q.vol;
  assign bus.tx_dv    = dv_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;
  assign tx_count     = count_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboarded bench for tx_arbiter with N_SYS=4, GAP_CYCLES=2, TIMEOUT_CYCLES=8.
module tb_tx_arbiter;

  logic        clk;
  logic        reset;
  logic        busy;
  logic        err_timeout;
  logic [31:0] tx_count;

  tx_arbiter_if #(.N_SYS(4)) bus ();

  tx_arbiter #(
    .N_SYS          (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .tx_count    (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic        side;
    logic [31:0] price;
    logic [31:0] vol;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          model_ptr = 0;
  int          exp_count = 0;
  logic        sys_side[4];
  logic [31:0] sys_price[4];
  logic [31:0] sys_vol[4];

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Round-robin reference: first requester at or above model_ptr.
  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (model_ptr + k) % 4;
      if (r[j]) begin
        model_ptr = (j + 1) % 4;
        return j;
      end
    end
    return -1;
  endfunction

  task automatic push_exp(input int idx);
    exp_t e;
    e.addr  = idx;
    e.side  = sys_side[idx];
    e.price = sys_price[idx];
    e.vol   = sys_vol[idx];
    exp_q.push_back(e);
  endtask

  // Grant monitor: every tx_dv pops one expected grant; acks only alongside tx_dv.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_dv) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL grant_unexpected addr=%0d at cycle %0d", bus.tx_addr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.tx_addr !== 8'(mon_e.addr) || bus.tx_side !== mon_e.side ||
              bus.tx_price !== mon_e.price || bus.tx_vol !== mon_e.vol) begin
            n_err++;
            $display("FAIL grant_fields got addr=%0d side=%0b price=%h vol=%h want addr=%0d side=%0b price=%h vol=%h",
                     bus.tx_addr, bus.tx_side, bus.tx_price, bus.tx_vol,
                     mon_e.addr, mon_e.side, mon_e.price, mon_e.vol);
          end
          n_vec++;
          if (bus.ord_ack !== 4'(1 << mon_e.addr)) begin
            n_err++;
            $display("FAIL grant_ack got %b want %b", bus.ord_ack, 4'(1 << mon_e.addr));
          end
        end
      end else if (bus.ord_ack !== 4'b0000) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_stray got %b want 0000 at cycle %0d", bus.ord_ack, cyc);
      end
    end
  end

  task automatic drive_fields();
    for (int i = 0; i < 4; i++) begin
      bus.ord_side[i]           = sys_side[i];
      bus.ord_price[32*i +: 32] = sys_price[i];
      bus.ord_vol[32*i +: 32]   = sys_vol[i];
    end
  endtask

  // Wait for the next tx_dv, optionally drop the acked request, then answer tx_done after done_delay cycles (0 = never).
  task automatic serve(input int done_delay, input bit drop, output int dv_cyc);
    bit seen;
    seen   = 1'b0;
    dv_cyc = -1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.tx_dv === 1'b1) begin
        seen   = 1'b1;
        dv_cyc = cyc;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL serve_wait got no tx_dv want tx_dv within 40 cycles");
      return;
    end
    if (drop) bus.ord_req = bus.ord_req & ~bus.ord_ack;
    if (done_delay > 0) begin
      repeat (done_delay) @(negedge clk);
      bus.tx_done = 1'b1;
      exp_count++;
      @(negedge clk);
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.ord_ack !== 4'b0 || bus.tx_dv !== 1'b0 || bus.tx_addr !== 8'h0 ||
        bus.tx_side !== 1'b0 || bus.tx_price !== 32'h0 || bus.tx_vol !== 32'h0) begin
      n_err++;
      $display("FAIL reset_tx got ack=%b dv=%b addr=%h side=%b price=%h vol=%h want all 0",
               bus.ord_ack, bus.tx_dv, bus.tx_addr, bus.tx_side, bus.tx_price, bus.tx_vol);
    end
    n_vec++;
    if (busy !== 1'b0 || err_timeout !== 1'b0 || tx_count !== 32'h0) begin
      n_err++;
      $display("FAIL reset_status got busy=%b err=%b count=%0d want 0 0 0", busy, err_timeout, tx_count);
    end
    reset = 1'b0;
    model_ptr = 0;
    exp_count = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    exp_count = 0;
  endtask

  task automatic test_single();
    bus.ord_req = 4'b0100;
    push_exp(model_pick(4'b0100));
    @(negedge clk);
    n_vec++;
    if (bus.tx_dv !== 1'b1 || bus.ord_ack !== 4'b0100) begin
      n_err++;
      $display("FAIL single_latency got dv=%b ack=%b want dv=1 ack=0100", bus.tx_dv, bus.ord_ack);
    end
    bus.ord_req = 4'b0000;
    repeat (3) @(negedge clk);
    bus.tx_done = 1'b1;
    exp_count++;
    @(negedge clk);
    bus.tx_done = 1'b0;
    n_vec++;
    if (tx_count !== 32'(exp_count) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_count got count=%0d busy=%b want count=%0d busy=1", tx_count, busy, exp_count);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle got busy=%b want 0", busy);
    end
    n_vec++;
    if (bus.tx_addr !== 8'd2 || bus.tx_price !== 32'h100 || bus.tx_vol !== 32'd5 || bus.tx_side !== 1'b1) begin
      n_err++;
      $display("FAIL single_hold got addr=%0d price=%h vol=%0d side=%b want 2 100 5 1",
               bus.tx_addr, bus.tx_price, bus.tx_vol, bus.tx_side);
    end
  endtask

  task automatic test_fairness();
    int t, prev;
    do_reset();
    bus.ord_req = 4'b1111;
    for (int g = 0; g < 6; g++) push_exp(model_pick(4'b1111));
    prev = -1;
    for (int g = 0; g < 6; g++) begin
      if (g == 5) begin
        serve(1, 1'b0, t);
        bus.ord_req = 4'b0000;
      end else begin
        serve(1, 1'b0, t);
      end
      if (prev >= 0) begin
        n_vec++;
        if (t - prev !== 5) begin
          n_err++;
          $display("FAIL fair_spacing got %0d cycles want 5", t - prev);
        end
      end
      prev = t;
    end
    n_vec++;
    if (tx_count !== 32'(exp_count)) begin
      n_err++;
      $display("FAIL fair_count got %0d want %0d", tx_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    int t;
    bus.ord_req = 4'b1000;
    push_exp(model_pick(4'b1000));
    serve(1, 1'b1, t);
    bus.ord_req = 4'b1001;
    push_exp(model_pick(4'b1001));
    serve(1, 1'b1, t);
    push_exp(model_pick(bus.ord_req));
    serve(1, 1'b1, t);
    n_vec++;
    if (bus.ord_req !== 4'b0000 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL wrap_drain got req=%b pending=%0d want 0000 0", bus.ord_req, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int t;
    bus.ord_req = 4'b0010;
    push_exp(model_pick(4'b0010));
    serve(0, 1'b1, t);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_vec++;
      if (err_timeout !== 1'(k == 9)) begin
        n_err++;
        $display("FAIL timeout_pulse got %b want %b at %0d cycles after tx_dv", err_timeout, k == 9, k);
      end
    end
    n_vec++;
    if (tx_count !== 32'(exp_count)) begin
      n_err++;
      $display("FAIL timeout_count got %0d want %0d", tx_count, exp_count);
    end
    @(negedge clk);
    n_vec++;
    if (err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_width got %b want 0", err_timeout);
    end
    bus.ord_req = 4'b0100;
    push_exp(model_pick(4'b0100));
    serve(1, 1'b1, t);
    n_vec++;
    if (tx_count !== 32'(exp_count)) begin
      n_err++;
      $display("FAIL timeout_next got %0d want %0d", tx_count, exp_count);
    end
  endtask

  task automatic test_done_on_timeout();
    int t;
    bus.ord_req = 4'b0001;
    push_exp(model_pick(4'b0001));
    serve(8, 1'b1, t);
    n_vec++;
    if (err_timeout !== 1'b0 || tx_count !== 32'(exp_count)) begin
      n_err++;
      $display("FAIL done_on_timeout got err=%b count=%0d want err=0 count=%0d", err_timeout, tx_count, exp_count);
    end
  endtask

  task automatic test_done_in_idle();
    repeat (4) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_before got busy=%b want 0", busy);
    end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (tx_count !== 32'(exp_count) || busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL idle_done got count=%0d busy=%b err=%b want count=%0d busy=0 err=0",
               tx_count, busy, err_timeout, exp_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    int t;
    bus.ord_req = 4'b0100;
    push_exp(model_pick(4'b0100));
    serve(0, 1'b1, t);
    bus.ord_req = 4'b1010;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus.ord_ack !== 4'b0 || bus.tx_dv !== 1'b0 || bus.tx_addr !== 8'h0 || bus.tx_price !== 32'h0 ||
        bus.tx_vol !== 32'h0 || bus.tx_side !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0 || tx_count !== 32'h0) begin
      n_err++;
      $display("FAIL reset_async got ack=%b dv=%b addr=%h busy=%b err=%b count=%0d want all 0",
               bus.ord_ack, bus.tx_dv, bus.tx_addr, busy, err_timeout, tx_count);
    end
    model_ptr = 0;
    exp_count = 0;
    @(negedge clk);
    reset = 1'b0;
    push_exp(model_pick(4'b1010));
    serve(1, 1'b1, t);
    push_exp(model_pick(bus.ord_req));
    serve(1, 1'b1, t);
    n_vec++;
    if (tx_count !== 32'(exp_count)) begin
      n_err++;
      $display("FAIL reset_recover got %0d want %0d", tx_count, exp_count);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.ord_req   = 4'b0000;
    bus.tx_done   = 1'b0;
    sys_side[0] = 1'b0; sys_price[0] = 32'h0000_00A0; sys_vol[0] = 32'd7;
    sys_side[1] = 1'b1; sys_price[1] = 32'h1234_5678; sys_vol[1] = 32'd11;
    sys_side[2] = 1'b1; sys_price[2] = 32'h0000_0100; sys_vol[2] = 32'd5;
    sys_side[3] = 1'b0; sys_price[3] = 32'hFFFF_FFFF; sys_vol[3] = 32'hDEAD_BEEF;
    drive_fields();

    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_done_on_timeout();
    test_done_in_idle();
    test_reset_mid_wait();

    repeat (6) @(negedge clk);
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
